dds_sample_formatter: RTL and testbench

//   Parametrised, pipelined sample-format stage between the DDS phase/LUT core and the DAC interface.

---
 rtl/dds_sample_formatter.sv | 122 ++++++++++++
 tb/tb_dds_sample_formatter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sample_formatter.sv
// Two-stage DDS-to-DAC sample formatter: S1 converts unsigned samples to signed per mode,
// S2 adds a signed DC offset with saturation; valid/ready on both sides, 2-cycle latency, 1 sample/clk.
module dds_sample_formatter #(
  parameter int DATA_W   = 14,
  parameter int SATCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   dc_offset,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                sat_clr,
  output logic [SATCNT_W-1:0] sat_cnt
);

  localparam logic [DATA_W-1:0]   SMIN     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]   SMAX     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [SATCNT_W-1:0] CNT_FULL = {SATCNT_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_OFFBIN = 2'd1,
    MODE_FSMIN  = 2'd2,
    MODE_NEG    = 2'd3
  } mode_t;

  logic              adv1;
  logic              adv2;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_c;
  logic [DATA_W-1:0] s1_off;
  logic              s1_sat;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic              s2_sat;

  logic [DATA_W-1:0] conv_c;
  logic              conv_sat;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] clamp_data;
  logic              clamp_hit;
  logic              out_xfer;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_xfer  = s2_valid && out_ready;

  // Conversion wraps modulo 2^DATA_W; only negating the most negative value needs a clamp.
  always_comb begin
    conv_c   = in_data;
    conv_sat = 1'b0;
    case (mode_t'(mode))
      MODE_PASS:   conv_c = in_data;
      MODE_OFFBIN: conv_c = in_data ^ SMIN;
      MODE_FSMIN:  conv_c = SMAX - in_data;
      MODE_NEG: begin
        if (in_data == SMIN) begin
          conv_c   = SMAX;
          conv_sat = 1'b1;
        end else begin
          conv_c = -in_data;
        end
      end
      default: conv_c = in_data;
    endcase
  end

  // One guard bit is enough: the two top sum bits disagree exactly when the result left range.
  always_comb begin
    sum        = {s1_c[DATA_W-1], s1_c} + {s1_off[DATA_W-1], s1_off};
    clamp_hit  = sum[DATA_W] != sum[DATA_W-1];
    clamp_data = sum[DATA_W-1:0];
    if (clamp_hit) begin
      clamp_data = sum[DATA_W] ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_c     <= '0;
      s1_off   <= '0;
      s1_sat   <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= 1'b0;
      sat_cnt  <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_c   <= conv_c;
          s1_off <= dc_offset;
          s1_sat <= conv_sat;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= clamp_data;
          s2_sat  <= s1_sat || clamp_hit;
        end
      end
      if (sat_clr) begin
        sat_cnt <= '0;
      end else if (out_xfer && s2_sat && (sat_cnt != CNT_FULL)) begin
        sat_cnt <= sat_cnt + SATCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dds_sample_formatter.sv
// Scoreboard bench for dds_sample_formatter: stimulus pushes model results, a negedge monitor pops and compares.
module tb_dds_sample_formatter;

  localparam int W    = 14;
  localparam int SW   = 4;
  localparam int HALF = 1 << (W - 1);
  localparam int FULL = 1 << W;
  localparam int SATMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [W-1:0]  dc_offset;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          sat_clr;
  logic [SW-1:0] sat_cnt;

  typedef struct {
    int data;
    bit sat;
    int acc;
    bit exact;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   rdy_mode    = 0;
  bit   lat_exact   = 1'b0;
  int   exp_sat     = 0;

  dds_sample_formatter #(.DATA_W(W), .SATCNT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .dc_offset (dc_offset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  function automatic int sx(input int v);
    int m;
    m = v & (FULL - 1);
    return (m >= HALF) ? m - FULL : m;
  endfunction

  // Reference: signed arithmetic on plain integers, then clamp to the signed DATA_W range.
  function automatic void ref_fmt(input int x, input int m, input int off, output int y, output bit s);
    int c;
    int total;
    s = 1'b0;
    case (m)
      0: c = sx(x);
      1: c = sx(x ^ HALF);
      2: c = sx(HALF - 1 - x);
      default: begin
        if (sx(x) == -HALF) begin
          c = HALF - 1;
          s = 1'b1;
        end else begin
          c = -sx(x);
        end
      end
    endcase
    total = c + sx(off);
    if (total > HALF - 1) begin
      total = HALF - 1;
      s = 1'b1;
    end else if (total < -HALF) begin
      total = -HALF;
      s = 1'b1;
    end
    y = total & (FULL - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the sample has been accepted.
  task automatic send(input int x);
    int budget;
    int y;
    bit s;
    budget   = 0;
    in_data  = x[W-1:0];
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      ref_fmt(x, int'(mode), int'(dc_offset), y, s);
      sb.push_back('{y, s, cyc, lat_exact});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   flag;
    flag = 1'b0;
    if (rst) begin
      sb.delete();
      exp_sat = 0;
    end else begin
      if (out_valid && out_ready) begin
        chk("sat_cnt", int'(sat_cnt), exp_sat);
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_data", int'(out_data), e.data);
          flag = e.sat;
          if (e.exact) chk("latency", cyc - e.acc, 2);
          else if (cyc - e.acc < 2) chk("latency_min", cyc - e.acc, 2);
        end
      end
      if (sat_clr) exp_sat = 0;
      else if (flag && exp_sat != SATMAX) exp_sat++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int budget;
    int x;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'd0; dc_offset = '0; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_sat_cnt", int'(sat_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Full-scale-minus, back-to-back, exact 2-cycle latency.
    lat_exact = 1'b1;
    mode = 2'd2;
    send(16'h0000); send(16'h1FFF); send(16'h3FFF);
    idle(4);
    lat_exact = 1'b0;

    mode = 2'd1;
    send(16'h2000); send(16'h0000);
    mode = 2'd3;
    send(16'h2000); send(16'h0005);
    idle(4);
    mode = 2'd1; dc_offset = 14'h0001;
    send(16'h3FFF);
    dc_offset = 14'h2000;
    send(16'h0000);
    idle(4);
    dc_offset = '0;
    chk("sat_cnt_directed", int'(sat_cnt), 3);

    // 8-sample stream, 3-cycle stall mid-stream, mode switch while stalled.
    mode = 2'd1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i * 1500 + 7);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #2;
        mode = 2'd2;
        @(negedge clk);
        chk("stall_in_ready_a", int'(in_ready), 0);
        @(negedge clk);
        chk("stall_in_ready_b", int'(in_ready), 0);
        @(negedge clk);
        rdy_mode = 0;
      end
    join
    idle(6);

    // Reset with a sample waiting in S2.
    rdy_mode = 2;
    mode = 2'd0;
    @(posedge clk);
    #1;
    send(16'h0123); send(16'h0456);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_out_valid", int'(out_valid), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send(16'h0777); send(16'h0888);
    idle(4);

    // Clear has priority over a saturating transfer.
    mode = 2'd3;
    sat_clr = 1'b1;
    send(16'h2000); send(16'h2000); send(16'h2000);
    idle(4);
    sat_clr = 1'b0;
    chk("sat_clr_priority", int'(sat_cnt), 0);
    send(16'h2000);
    idle(4);
    chk("sat_cnt_after_clr", int'(sat_cnt), 1);
    for (int i = 0; i < 20; i++) send(16'h2000);
    idle(4);
    chk("sat_cnt_sticks", int'(sat_cnt), SATMAX);

    // Randomized traffic with random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      mode      = 2'($urandom_range(0, 3));
      dc_offset = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      case ($urandom_range(0, 7))
        0:       x = 0;
        1:       x = HALF;
        2:       x = HALF - 1;
        3:       x = FULL - 1;
        default: x = int'($urandom_range(0, FULL - 1));
      endcase
      sat_clr = ($urandom_range(0, 15) == 0);
      send(x);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    rdy_mode = 0;
    budget = 0;
    while (sb.size() > 0 && budget < 200) begin
      budget++;
      @(posedge clk);
    end
    #1;
    chk("drain_remaining", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
